// File: rtl/alu_arbiter_if.sv
// Requester/result bundle for alu_arbiter.
// master: requester side (drives req/op/a/b, observes gnt/done/res/busy).
// slave : arbiter side (observes requests, drives grants, results and busy).
interface alu_arb_if;
    logic              req0;
    logic        [1:0] op0;
    logic signed [3:0] a0;
    logic signed [3:0] b0;
    logic              req1;
    logic        [1:0] op1;
    logic signed [3:0] a1;
    logic signed [3:0] b1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic signed [4:0] res0;
    logic signed [4:0] res1;
    logic              busy;

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1,
        input  gnt0, gnt1, done0, done1, res0, res1, busy
    );

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1,
        output gnt0, gnt1, done0, done1, res0, res1, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared 4-bit signed ALU.
// One operation in flight at a time: IDLE (sample) -> EXEC (gnt) -> RESP (done).
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - alu_arb_if.slave: req/op/a/b per requester in, gnt/done/res/busy out
// Build option: define ALU_ARB_RR_EN for round-robin arbitration on
// contention; otherwise requester 0 has fixed priority.
module alu_arbiter (
    input  logic      clk,
    input  logic      reset,
    alu_arb_if.slave  bus
);

    localparam int unsigned OP_W  = 2;
    localparam int unsigned OPD_W = 4;
    localparam int unsigned RES_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state, state_d;
    logic                     win, win_d;
    logic        [OP_W-1:0]   op_q, op_d;
    logic signed [OPD_W-1:0]  a_q, a_d;
    logic signed [OPD_W-1:0]  b_q, b_d;
    logic                     gnt0_d, gnt1_d;
    logic                     done0_d, done1_d;
    logic signed [RES_W-1:0]  res0_d, res1_d;
    logic signed [RES_W-1:0]  alu_res;
    logic                     pick1;

`ifdef ALU_ARB_RR_EN
    logic                     last, last_d;   // 1: requester 1 was granted last
`endif

    // Shared ALU; operands sign-extended to the 5-bit result width.
    function automatic logic signed [RES_W-1:0] alu_f(
        input logic        [OP_W-1:0]  op,
        input logic signed [OPD_W-1:0] a,
        input logic signed [OPD_W-1:0] b
    );
        logic signed [RES_W-1:0] ax;
        logic signed [RES_W-1:0] bx;
        ax = {a[OPD_W-1], a};
        bx = {b[OPD_W-1], b};
        case (op)
            2'b00:   alu_f = ax + bx;
            2'b01:   alu_f = ax - bx;
            2'b10:   alu_f = ~ax;
            default: alu_f = {4'b0000, |b};
        endcase
    endfunction

    // Winner select; only meaningful when at least one request is present.
`ifdef ALU_ARB_RR_EN
    assign pick1 = bus.req1 && (!bus.req0 || !last);
`else
    assign pick1 = !bus.req0;
`endif

    assign alu_res = alu_f(op_q, a_q, b_q);

    // State, captured operation and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            win       <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            bus.res0  <= '0;
            bus.res1  <= '0;
            bus.busy  <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last      <= 1'b1;
`endif
        end else begin
            state     <= state_d;
            win       <= win_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            bus.gnt0  <= gnt0_d;
            bus.gnt1  <= gnt1_d;
            bus.done0 <= done0_d;
            bus.done1 <= done1_d;
            bus.res0  <= res0_d;
            bus.res1  <= res1_d;
            bus.busy  <= (state_d != IDLE);
`ifdef ALU_ARB_RR_EN
            last      <= last_d;
`endif
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d = state;
        win_d   = win;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        res0_d  = '0;
        res1_d  = '0;
`ifdef ALU_ARB_RR_EN
        last_d  = last;
`endif
        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = EXEC;
                    win_d   = pick1;
                    op_d    = pick1 ? bus.op1 : bus.op0;
                    a_d     = pick1 ? bus.a1  : bus.a0;
                    b_d     = pick1 ? bus.b1  : bus.b0;
                    gnt0_d  = !pick1;
                    gnt1_d  = pick1;
`ifdef ALU_ARB_RR_EN
                    last_d  = pick1;
`endif
                end
            end
            EXEC: begin
                state_d = RESP;
                done0_d = !win;
                done1_d = win;
                res0_d  = win ? RES_W'(0) : alu_res;
                res1_d  = win ? alu_res   : RES_W'(0);
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: the driver predicts grants/results from
// the arbitration and ALU rules and queues them; a monitor compares outputs.
module tb_alu_arbiter;

    typedef struct {
        int cyc;
        int id;
        int res;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   edge_cnt = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t gq[$];
    exp_t dq[$];
    int   free_edge = 0;
    bit   gnt_pred [2];
`ifdef ALU_ARB_RR_EN
    int   m_last = 1;
`endif

    alu_arb_if bus ();

    alu_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0d exp=%0d", name, edge_cnt, got, exp);
        end
    endtask

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return -a - 1;
            default: return (b != 0) ? 1 : 0;
        endcase
    endfunction

    task automatic set_req(input int id, input bit r, input int op, input int a, input int b);
        if (id == 0) begin
            bus.req0 = r;
            bus.op0  = 2'(op);
            bus.a0   = 4'(a);
            bus.b0   = 4'(b);
        end else begin
            bus.req1 = r;
            bus.op1  = 2'(op);
            bus.a1   = 4'(a);
            bus.b1   = 4'(b);
        end
    endtask

    task automatic flush(input int e);
        exp_t t[$];
        foreach (gq[k]) if (gq[k].cyc < e) t.push_back(gq[k]);
        gq = t;
        t = {};
        foreach (dq[k]) if (dq[k].cyc < e) t.push_back(dq[k]);
        dq = t;
    endtask

    // Predict what the coming rising edge does with the inputs now applied.
    task automatic predict();
        int e;
        int w;
        e = edge_cnt + 1;
        gnt_pred[0] = 1'b0;
        gnt_pred[1] = 1'b0;
        if (reset) begin
            flush(e);
            free_edge = e + 1;
`ifdef ALU_ARB_RR_EN
            m_last = 1;
`endif
        end else if (e >= free_edge && (bus.req0 || bus.req1)) begin
`ifdef ALU_ARB_RR_EN
            if (bus.req0 && bus.req1) w = (m_last == 1) ? 0 : 1;
            else                      w = bus.req0 ? 0 : 1;
            m_last = w;
`else
            w = bus.req0 ? 0 : 1;
`endif
            gq.push_back('{e, w, 0});
            if (w == 0) dq.push_back('{e + 1, 0, ref_alu(int'(bus.op0), int'(bus.a0), int'(bus.b0))});
            else        dq.push_back('{e + 1, 1, ref_alu(int'(bus.op1), int'(bus.a1), int'(bus.b1))});
            free_edge   = e + 3;
            gnt_pred[w] = 1'b1;
        end
    endtask

    task automatic step();
        predict();
        @(negedge clk);
    endtask

    task automatic run_op(input int id, input int op, input int a, input int b);
        bit seen;
        seen = 1'b0;
        set_req(id, 1'b1, op, a, b);
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            seen = gnt_pred[id];
        end
        chk("grant_wait", int'(seen), 1);
        // Operand A changes while the operation is in flight.
        set_req(id, 1'b0, op, 0, b);
        repeat (3) step();
    endtask

    // Monitor: compare every cycle against queued expectations.
    always @(negedge clk) begin
        logic [1:0] eg;
        logic [1:0] ed;
        int er0;
        int er1;
        eg  = 2'b00;
        ed  = 2'b00;
        er0 = 0;
        er1 = 0;
        while (gq.size() > 0 && gq[0].cyc < edge_cnt) begin
            chk("stale_gnt", gq[0].cyc, edge_cnt);
            void'(gq.pop_front());
        end
        while (dq.size() > 0 && dq[0].cyc < edge_cnt) begin
            chk("stale_done", dq[0].cyc, edge_cnt);
            void'(dq.pop_front());
        end
        if (gq.size() > 0 && gq[0].cyc == edge_cnt) begin
            eg[gq[0].id] = 1'b1;
            void'(gq.pop_front());
        end
        if (dq.size() > 0 && dq[0].cyc == edge_cnt) begin
            ed[dq[0].id] = 1'b1;
            if (dq[0].id == 0) er0 = dq[0].res;
            else               er1 = dq[0].res;
            void'(dq.pop_front());
        end
        chk("gnt",  int'({bus.gnt1, bus.gnt0}), int'(eg));
        chk("done", int'({bus.done1, bus.done0}), int'(ed));
        chk("res0", int'(bus.res0), er0);
        chk("res1", int'(bus.res1), er1);
        chk("busy", int'(bus.busy), int'((|eg) || (|ed)));
    end

    initial begin
        reset = 1'b1;
        set_req(0, 1'b1, 0, 1, 1);
        set_req(1, 1'b0, 0, 0, 0);

        // Requests during reset are ignored; grant on first edge after release.
        step();
        step();
        reset = 1'b0;
        step();
        set_req(0, 1'b0, 0, 1, 1);
        repeat (3) step();

        // Directed ALU cases.
        run_op(0, 0, 7, 7);
        run_op(0, 0, -8, -8);
        run_op(1, 1, -8, 7);
        run_op(1, 2, 7, 0);
        run_op(1, 3, 5, 12);
        run_op(1, 3, 5, 0);
        run_op(0, 0, 7, 1);

        // Contention with both requests held.
        set_req(0, 1'b1, 0, 1, 2);
        set_req(1, 1'b1, 1, 3, 1);
        repeat (13) step();
        set_req(0, 1'b0, 0, 1, 2);
        set_req(1, 1'b0, 1, 3, 1);
        repeat (3) step();

        // Reset during EXEC aborts the operation.
        set_req(0, 1'b1, 0, 3, 2);
        step();
        set_req(0, 1'b0, 0, 3, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();

        // Randomized traffic.
        repeat (400) begin
            for (int i = 0; i < 2; i++) begin
                bit cur;
                cur = (i == 0) ? bus.req0 : bus.req1;
                if (gnt_pred[i]) begin
                    set_req(i, 1'($urandom_range(1)), int'($urandom_range(3)),
                            int'($urandom_range(15)), int'($urandom_range(15)));
                end else if (!cur && $urandom_range(2) == 0) begin
                    set_req(i, 1'b1, int'($urandom_range(3)),
                            int'($urandom_range(15)), int'($urandom_range(15)));
                end
            end
            reset = ($urandom_range(40) == 0);
            step();
        end
        reset = 1'b0;
        set_req(0, 1'b0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0);
        repeat (5) step();

        chk("queue_drain", gq.size() + dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: none; all widths fixed (opcode 2 b, operands signed 4 b, result signed 5 b).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 operation request; held high until gnt0 is seen.
REQ-005 op0  input  2  requester 0 opcode: 00 add, 01 sub, 10 invert A, 11 reduction-OR B.
REQ-006 a0  input  4  requester 0 operand A, signed.
REQ-007 b0  input  4  requester 0 operand B, signed.
REQ-008 req1, op1, a1, b1  input  1/2/4/4  requester 1 request, opcode and operands; same rules as requester 0.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands of the granted requester were captured on the edge that raised it.
REQ-010 done0, done1  output  1 each  one-cycle result-valid pulse to the owning requester.
REQ-011 res0, res1  output  5 each  signed result; valid only while the matching done is high, 0 otherwise.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 FSM states IDLE, EXEC, RESP; IDLE->EXEC on any request, EXEC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-014 In IDLE with a request present, the edge SHALL latch winner id, opcode, A and B, enter EXEC, and gnt of the winner SHALL be high for exactly the EXEC cycle.
REQ-015 At the EXEC->RESP edge the result SHALL be registered; done and res of the winner SHALL be valid for exactly the RESP cycle.
REQ-016 Latency: request sampled at edge N -> gnt during cycle N..N+1 -> done during cycle N+1..N+2; maximum throughput one operation per 3 cycles.
REQ-017 Requests are sampled only in IDLE; requests, operand or opcode changes during EXEC/RESP SHALL have no effect on the operation in flight.
REQ-018 A request still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-019 Add: C = sext5(A) + sext5(B); sub: C = sext5(A) - sext5(B); no overflow possible, no saturation.
REQ-020 Invert: C = sext5(~A); reduction-OR: C = {4'b0000, |B}; the unused operand is ignored.
REQ-021 gnt0/gnt1 SHALL never be high together; likewise done0/done1.
REQ-022 Arbitration when both requests are high in IDLE per REQ-034/REQ-035; a single request is always granted.

Reset
REQ-023 reset high at a rising edge SHALL force state IDLE, clear latched opcode/operands/result, and set last-grant pointer to requester 1.
REQ-024 Outputs during and after reset until the next grant: gnt0=gnt1=done0=done1=0, res0=res1=0, busy=0.
REQ-025 Reset asserted in EXEC or RESP SHALL abort the operation; no done pulse SHALL follow for it.
REQ-026 Requests high during reset SHALL be ignored; the first grant may occur on the first edge with reset low.

Configuration
REQ-027 Macro ALU_ARB_RR_EN selects the arbitration policy.
REQ-034 With ALU_ARB_RR_EN defined: round-robin; on contention the requester not granted last wins; pointer updates on every grant.
REQ-035 Without ALU_ARB_RR_EN: fixed priority, requester 0 always wins contention; pointer logic absent.

Verification
REQ-028 Reset: reset=1 two cycles with req0=1 -> gnt*, done*, busy, res* all 0; after release gnt0 next cycle.
REQ-029 Add: req0, op0=00, a0=7, b0=7 -> gnt0 one cycle, then done0 with res0=14; a0=-8,b0=-8 -> res0=-16.
REQ-030 Sub/invert/OR: req1 op1=01 a1=-8 b1=7 -> res1=-15; op1=10 a1=7 -> res1=-8; op1=11 b1=4'b1100 -> res1=1; b1=0 -> res1=0.
REQ-031 Contention: req0=req1=1 held, after reset -> grant order 0,1,0,1 with ALU_ARB_RR_EN; 0,0,0 without; each done 3 cycles apart.
REQ-032 Mid-op reset: assert reset during the EXEC cycle of a0=3,b0=2 add -> no done0, res0=0, busy=0 next cycle.
REQ-033 Operand change after grant: a0 7->0 during EXEC with op0=00,b0=1 -> res0=8 (captured value used).
